// File: rtl/keypad_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_pkg : shared constants, event type and encoder helper for keypad_ctrl
// Revision   : 1.0
// ---------------------------------------------------------------------------
package keypad_pkg;

   localparam int KEY_NUM      = 16;
   localparam int KEY_W        = 4;
   localparam int DEF_TICK_DIV = 50000;
   localparam int DEF_DEB_N    = 4;

   typedef struct packed {
      logic             press;
      logic [KEY_W-1:0] code;
   } evt_t;

   // Lowest set bit wins, so simultaneous transitions leave in key-index order.
   function automatic logic [KEY_W-1:0] lowest_set(input logic [KEY_NUM-1:0] v);
      logic [KEY_W-1:0] idx;
      idx = '0;
      for (int i = KEY_NUM - 1; i >= 0; i--) begin
         if (v[i]) idx = KEY_W'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_evt_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// evt_fifo : synchronous circular-buffer FIFO, simultaneous push/pop allowed
// Revision : 1.0
// ---------------------------------------------------------------------------
module evt_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_count;
   logic             w_pop;
   logic             w_push;

   assign empty  = (r_count == '0);
   assign full   = (r_count == (AW+1)'(DEPTH));
   assign w_pop  = pop & ~empty;
   // When full, a same-cycle pop frees the head slot the write lands in.
   assign w_push = push & (~full | w_pop);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= din;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   assign dout  = r_mem[r_rd];
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/keypad_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_ctrl : resync, debounce and event-queue front end for a 4x4 keypad
// Revision    : 1.0
// ---------------------------------------------------------------------------
module keypad_ctrl
   import keypad_pkg::*;
#(
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int DEB_N      = DEF_DEB_N,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [KEY_NUM-1:0]            key_raw,
   input  logic                          pop,
   input  logic                          clr_ovf,
   output logic                          evt_valid,
   output logic [KEY_W-1:0]              evt_code,
   output logic                          evt_press,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic [KEY_NUM-1:0]            stable,
   output logic                          ovf,
   output logic                          irq
);

   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] c_TICK_MAX = TW'(TICK_DIV - 1);

   logic [KEY_NUM-1:0] r_sync1, r_sync2;
   logic [KEY_NUM-1:0] w_s;
   logic [TW-1:0]      r_tick_cnt;
   logic               w_tick;
   logic [DEB_N-1:0]   r_hist [KEY_NUM];
   logic [KEY_NUM-1:0] r_stable, r_pend, w_toggle, w_clr;
   logic               r_ovf;
   logic [KEY_W-1:0]   w_sel;
   evt_t               w_evt, w_head;
   logic               w_full, w_empty, w_push;

   assign w_s    = ~r_sync2;
   assign w_tick = (r_tick_cnt == c_TICK_MAX);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync1    <= '1;
         r_sync2    <= '1;
         r_tick_cnt <= '0;
         for (int i = 0; i < KEY_NUM; i++) r_hist[i] <= '0;
      end else begin
         r_sync1 <= key_raw;
         r_sync2 <= r_sync1;
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
         if (w_tick) begin
            for (int i = 0; i < KEY_NUM; i++)
               r_hist[i] <= {r_hist[i][DEB_N-2:0], w_s[i]};
         end
      end
   end

   always_comb begin
      w_toggle = '0;
      for (int i = 0; i < KEY_NUM; i++) begin
         w_toggle[i] = ((&r_hist[i]) | ~(|r_hist[i])) & (r_hist[i][0] ^ r_stable[i]);
      end
   end

   assign w_sel      = lowest_set(r_pend);
   assign w_evt.press = r_stable[w_sel];
   assign w_evt.code  = w_sel;
   assign w_push     = (|r_pend) & (~w_full | (pop & ~w_empty));
   assign w_clr      = w_push ? (KEY_NUM'(1) << w_sel) : '0;

   // A toggle on a still-pending key merges into one event carrying the latest state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stable <= '0;
         r_pend   <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_stable <= r_stable ^ w_toggle;
         r_pend   <= (r_pend & ~w_clr) | w_toggle;
         if (|(w_toggle & r_pend & ~w_clr)) r_ovf <= 1'b1;
         else if (clr_ovf)                  r_ovf <= 1'b0;
      end
   end

   evt_fifo #(
      .WIDTH (KEY_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (w_push),
      .pop   (pop),
      .din   (w_evt),
      .dout  (w_head),
      .count (evt_count),
      .full  (w_full),
      .empty (w_empty)
   );

   assign evt_valid = ~w_empty;
   assign irq       = ~w_empty;
   assign evt_code  = w_head.code;
   assign evt_press = w_head.press;
   assign stable    = r_stable;
   assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_keypad_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_keypad_ctrl : directed self-checking bench for keypad_ctrl
// Revision       : 1.1
// ---------------------------------------------------------------------------
module tb_keypad_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] key_raw;
    logic        pop;
    logic        clr_ovf;
    logic        evt_valid;
    logic [3:0]  evt_code;
    logic        evt_press;
    logic [2:0]  evt_count;
    logic [15:0] stable;
    logic        ovf;
    logic        irq;

    int checks = 0;
    int errors = 0;

    keypad_ctrl #(
        .TICK_DIV   (4),
        .DEB_N      (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .key_raw   (key_raw),
        .pop       (pop),
        .clr_ovf   (clr_ovf),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_press (evt_press),
        .evt_count (evt_count),
        .stable    (stable),
        .ovf       (ovf),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_stable(input logic [15:0] exp, input string tag);
        for (int k = 0; k < 400; k++) begin
            if (stable === exp) break;
            step(1);
        end
        check(tag, stable, exp);
    endtask

    task automatic pop_expect(input logic [3:0] code, input logic press, input string tag);
        check({tag, "_valid"}, evt_valid, 1'b1);
        check({tag, "_code"},  evt_code,  code);
        check({tag, "_press"}, evt_press, press);
        pop = 1'b1;
        step(1);
        pop = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; key_raw = 16'hFFFF; pop = 1'b0; clr_ovf = 1'b0;
        step(3);
        check("rst_valid",  evt_valid, 1'b0);
        check("rst_code",   evt_code,  4'd0);
        check("rst_press",  evt_press, 1'b0);
        check("rst_count",  evt_count, 3'd0);
        check("rst_stable", stable,    16'h0000);
        check("rst_ovf",    ovf,       1'b0);
        check("rst_irq",    irq,       1'b0);
        rstn = 1'b1;
        step(2);

        key_raw = 16'hFFFB;
        wait_stable(16'h0004, "press_stable");
        check("press_pre_valid", evt_valid, 1'b0);
        step(1);
        check("press_count", evt_count, 3'd1);
        check("press_irq",   irq,       1'b1);
        pop_expect(4'd2, 1'b1, "press_evt");
        check("pop_valid", evt_valid, 1'b0);
        check("pop_count", evt_count, 3'd0);
        pop = 1'b1; step(1); pop = 1'b0;
        check("pop_empty_count", evt_count, 3'd0);
        key_raw = 16'hFFFF;
        wait_stable(16'h0000, "rel2_stable");
        step(1);
        pop_expect(4'd2, 1'b0, "rel2_evt");

        key_raw = 16'hFFDF; step(4);
        key_raw = 16'hFFFF; step(4);
        key_raw = 16'hFFDF; step(4);
        key_raw = 16'hFFFF; step(40);
        check("bounce_stable", stable,    16'h0000);
        check("bounce_count",  evt_count, 3'd0);

        key_raw = 16'hEF7D;
        wait_stable(16'h1082, "simul_stable");
        check("simul_c0", evt_count, 3'd0);
        step(1);
        check("simul_c1", evt_count, 3'd1);
        step(1);
        check("simul_c2", evt_count, 3'd2);
        step(1);
        check("simul_c3", evt_count, 3'd3);
        step(2);
        check("simul_c3_hold", evt_count, 3'd3);
        pop_expect(4'd1,  1'b1, "simul_e1");
        pop_expect(4'd7,  1'b1, "simul_e7");
        pop_expect(4'd12, 1'b1, "simul_e12");
        check("simul_empty", evt_valid, 1'b0);
        key_raw = 16'hFFFF;
        wait_stable(16'h0000, "simul_rel");
        step(4);
        pop_expect(4'd1,  1'b0, "simul_r1");
        pop_expect(4'd7,  1'b0, "simul_r7");
        pop_expect(4'd12, 1'b0, "simul_r12");

        key_raw = 16'hFFF8;
        wait_stable(16'h0007, "bp_press");
        step(4);
        check("bp_c3", evt_count, 3'd3);
        key_raw = 16'hFFFF;
        wait_stable(16'h0000, "bp_rel");
        step(3);
        check("bp_full", evt_count, 3'd4);
        check("bp_head", evt_code,  4'd0);
        pop = 1'b1;
        step(1);
        check("bp_pp1_count", evt_count, 3'd4);
        check("bp_pp1_head",  evt_code,  4'd1);
        step(1);
        pop = 1'b0;
        check("bp_pp2_count", evt_count, 3'd4);
        step(2);
        check("bp_hold_count", evt_count, 3'd4);
        check("bp_ovf", ovf, 1'b0);
        pop_expect(4'd2, 1'b1, "bp_p2");
        pop_expect(4'd0, 1'b0, "bp_r0");
        pop_expect(4'd1, 1'b0, "bp_r1");
        pop_expect(4'd2, 1'b0, "bp_r2");
        check("bp_empty", evt_valid, 1'b0);

        key_raw = 16'hFFF0;
        wait_stable(16'h000F, "ov_fill");
        step(6);
        check("ov_full", evt_count, 3'd4);
        key_raw = 16'hFDF0;
        wait_stable(16'h020F, "ov_p9");
        step(1);
        check("ov_before", ovf, 1'b0);
        key_raw = 16'hFFF0;
        wait_stable(16'h000F, "ov_r9");
        key_raw = 16'hFDF0;
        wait_stable(16'h020F, "ov_p9b");
        step(1);
        check("ov_set", ovf, 1'b1);
        pop_expect(4'd0, 1'b1, "ov_e0");
        pop_expect(4'd1, 1'b1, "ov_e1");
        pop_expect(4'd2, 1'b1, "ov_e2");
        pop_expect(4'd3, 1'b1, "ov_e3");
        pop_expect(4'd9, 1'b1, "ov_e9");
        step(3);
        check("ov_one9", evt_valid, 1'b0);
        check("ov_still", ovf, 1'b1);
        clr_ovf = 1'b1; step(1); clr_ovf = 1'b0;
        check("ov_clr", ovf, 1'b0);

        key_raw = 16'hFFFF;
        wait_stable(16'h0000, "rst_mid_rel");
        step(2);
        check("rst_mid_pre", evt_valid, 1'b1);
        rstn = 1'b0;
        #2;
        check("rst_mid_count",  evt_count, 3'd0);
        check("rst_mid_stable", stable,    16'h0000);
        step(1);
        rstn = 1'b1;
        step(40);
        check("rst_mid_quiet", evt_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_ctrl.md
# keypad_ctrl

Event controller for the 4x4 keypad matrix scanner. Takes the scanner's raw 16-bit key image, which is produced on the derived scan clock, and resynchronises it to the system clock. It then debounces each key, converts stable press/release transitions into coded events and buffers them in a small FIFO. The Cortex-M0 bus slave pops events from that FIFO and takes an interrupt from it.

## Interface
- TICK_DIV, 50000, system clocks per debounce sample tick (1 ms at 50 MHz); legal range 2..2^20
- DEB_N, 4, consecutive equal samples needed to change a key's stable state; legal range 2..8
- FIFO_DEPTH, 4, event FIFO depth; power of two, 2..16
- clk  in  1  system clock; single clock domain
- rstn  in  1  reset, asynchronous, active-low
- key_raw  in  16  scanner key image, bit i = key i, 0 = pressed; asynchronous to clk
- pop  in  1  pop FIFO head; ignored when evt_valid=0
- clr_ovf  in  1  clear sticky overflow flag
- evt_valid  out  1  FIFO non-empty; head event on evt_code/evt_press
- evt_code  out  4  key index of head event
- evt_press  out  1  1 = press, 0 = release
- evt_count  out  $clog2(FIFO_DEPTH)+1  events held
- stable  out  16  debounced key state, 1 = pressed
- ovf  out  1  sticky: a transition was lost
- irq  out  1  level interrupt, equals evt_valid

## Operation
- Sync: key_raw passes through a 2-flop synchroniser. The synchroniser output is inverted to give s[15:0], where 1 = pressed.
- Tick: a counter runs 0..TICK_DIV-1 and wraps to 0. tick=1 in the cycle the counter equals TICK_DIV-1.
- History: each key has a DEB_N-bit shift register. On tick, s[i] shifts in.
- Stable update: if all DEB_N history bits of key i are equal and differ from stable[i], stable[i] toggles on the next edge. pend[i] is set on the same edge.
- Encoder: if pend != 0, it selects the lowest set index i and emits event {press=stable[i], code=i}.
  - The event is pushed if the FIFO is not full, or if pop is asserted in the same cycle. pend[i] clears on push.
  - At most one push per cycle.
- Backpressure: while the FIFO is full and pop=0, events stay in pend and nothing is dropped.
- Overflow: if stable[i] toggles while pend[i] is already set and not being cleared in that cycle, pend[i] stays set and ovf is set.
  - Net effect: the FIFO receives the current state only, and one transition pair is lost.
- ovf clear: ovf clears on clr_ovf. If a set and a clear occur in the same cycle, set wins.
- FIFO: circular buffer with read and write pointers and a count.
  - Push and pop in the same cycle, including when full: both take effect and the count is unchanged.
  - Pop when empty: no effect.
- Reset mid-operation: all state returns to its reset value immediately. Pending events and FIFO contents are discarded.

## Timing
- Reset values:
  - History is all 0 (released); stable, pend, tick counter, FIFO pointers and count are 0.
  - Outputs: evt_valid=0, evt_code=0, evt_press=0, evt_count=0, stable=0, ovf=0, irq=0.
- Press latency:
  - key_raw change to s change: 2 clk.
  - s change to stable change: DEB_N ticks. The tick that shifts in the DEB_N-th equal sample makes the history uniform; stable and pend update on the next edge.
  - pend to evt_valid: 1 clk, with the FIFO empty and no lower-index pend bit set.
- Pop: the head is registered. The next head appears, or evt_valid drops, 1 clk after the pop edge.
- evt_count and irq update on the same edge as the push or pop that changes them.
- Glitches shorter than DEB_N-1 ticks never change stable.

## Structure
- Package keypad_pkg holds:
  - KEY_NUM=16 and KEY_W=4
  - the event typedef {press, code[3:0]}
  - default TICK_DIV and DEB_N constants
- Sub-module evt_fifo: a parameterised synchronous FIFO with push, pop, din, dout, count, full and empty.
- Synchroniser, tick counter, debounce and encoder stay inline.

## Test plan
- Use TICK_DIV=4 and DEB_N=4 for all scenarios.
- Reset/press: reset, then hold key_raw=16'hFFFB (key 2 pressed).
  - Required: stable=16'h0004; one event {press=1, code=2}; evt_valid and irq rise.
  - Pop: evt_valid=0 and evt_count=0.
- Bounce: toggle bit 5 every tick for 3 ticks, then release.
  - Required: stable stays 0 and no events.
- Simultaneous keys: keys 1, 7 and 12 become stable in the same cycle.
  - Required: events pushed in code order 1, 7, 12 on consecutive cycles; evt_count=3.
- Full backpressure: with no pops, press then release keys 0 through 2.
  - Required: 4 events are held and evt_count=4; the remaining 2 events wait in pend.
  - Pop twice: the remaining events follow in order; ovf=0.
- Overflow: FIFO full and key 9 pend set; release and re-press key 9.
  - Required: ovf=1.
  - Draining: exactly one key 9 event, press=1.
  - clr_ovf=1 for one cycle: ovf=0.
- Pop with full FIFO and pend set in the same cycle: evt_count stays 4 and the new event lands at the tail.
